matrix_frame_scanner: RTL and testbench

Downstream display stage for the pong game. The game stage writes whole 8x8 red/green column bitmaps into a back buffer and requests a swap. This block double-buffers the frames and drives the bicolour LED matrix. It time-multiplexes 8 columns x 2 colours with a blanking gap between slots, so ghosting is removed and bitmaps replace the ad-hoc per-object multiplexing.

---
 rtl/matrix_frame_scanner_if.sv | 21 ++
 rtl/matrix_frame_scanner.sv | 151 +++++++++++++++
 tb/tb_matrix_frame_scanner.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_frame_scanner_if.sv
// Frame-write and swap handshake between the game stage (master) and the
// matrix frame scanner (slave).
interface matrix_frame_scanner_if;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [7:0] wr_red;
    logic [7:0] wr_grn;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_start;

    modport master (
        output wr_en, wr_col, wr_red, wr_grn, swap_req,
        input  swap_ack, frame_start
    );

    modport slave (
        input  wr_en, wr_col, wr_red, wr_grn, swap_req,
        output swap_ack, frame_start
    );
endinterface

// File: rtl/matrix_frame_scanner.sv
// Double-buffered 8x8 bicolour LED matrix scanner with per-slot blanking.
// Optional MATRIX_BRIGHTNESS_EN adds a 3-bit brightness input that shortens the drive window.
module matrix_frame_scanner #(
    parameter int CLK_HZ       = 50000000,
    parameter int FRAME_HZ     = 100,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    matrix_frame_scanner_if.slave        bus,
`ifdef MATRIX_BRIGHTNESS_EN
    input  logic [2:0]                   brightness,
`endif
    output logic [7:0]                   rows,
    output logic [7:0]                   colsr,
    output logic [7:0]                   colsg
);
    localparam int SLOT_CYC = CLK_HZ / (FRAME_HZ * 16);
    localparam int CW       = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int ACTIVE   = SLOT_CYC - BLANK_CYCLES;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             slot_q, slot_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   front_sel_q, front_sel_d;
    logic                   swapped_q, swapped_d;
    logic [1:0][7:0][7:0]   red_q, red_d;
    logic [1:0][7:0][7:0]   grn_q, grn_d;
    logic [7:0]             rows_q, rows_d;
    logic [7:0]             colsr_q, colsr_d;
    logic [7:0]             colsg_q, colsg_d;
    logic                   swap_ack_q, swap_ack_d;
    logic                   frame_start_q, frame_start_d;
    logic                   cnt_last, frame0, back;
    logic [2:0]             col;
    logic [31:0]            drive_len, cnt_ext;
`ifdef MATRIX_BRIGHTNESS_EN
    logic [2:0]             bright_q, bright_d, bright_eff;
`endif

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        cnt_d         = cnt_q;
        front_sel_d   = front_sel_q;
        swapped_d     = 1'b0;
        red_d         = red_q;
        grn_d         = grn_q;
        rows_d        = 8'h00;
        colsr_d       = 8'h00;
        colsg_d       = 8'h00;
        cnt_last      = (cnt_q == CNT_LAST);
        frame0        = (slot_q == 4'd0) && (cnt_q == '0);
        back          = ~front_sel_q;
        col           = slot_q[3:1];
        frame_start_d = frame0;
        swap_ack_d    = swapped_q;

        // Brightness is latched at the frame's first cycle and used directly in that cycle.
`ifdef MATRIX_BRIGHTNESS_EN
        bright_eff = frame0 ? brightness : bright_q;
        bright_d   = bright_eff;
        drive_len  = (32'(ACTIVE) * (32'(bright_eff) + 32'd1)) >> 3;
        if (drive_len == 32'd0) begin
            drive_len = 32'd1;
        end
`else
        drive_len = 32'(ACTIVE);
`endif

        if (cnt_last) begin
            cnt_d  = '0;
            slot_d = slot_q + 4'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Swapping only on the frame's last cycle keeps every displayed frame whole.
        if ((slot_q == 4'd15) && cnt_last && bus.swap_req) begin
            front_sel_d = ~front_sel_q;
            swapped_d   = 1'b1;
        end

        if (bus.wr_en) begin
            red_d[back][bus.wr_col] = bus.wr_red;
            grn_d[back][bus.wr_col] = bus.wr_grn;
        end

        cnt_ext = 32'(cnt_d);
        if ((cnt_ext >= 32'(BLANK_CYCLES)) && (cnt_ext < 32'(BLANK_CYCLES) + drive_len)) begin
            state_d = ST_DRIVE;
        end else begin
            state_d = ST_BLANK;
        end

        if (state_q == ST_DRIVE) begin
            if (!slot_q[0]) begin
                rows_d  = red_q[front_sel_q][col];
                colsr_d = 8'd1 << col;
            end else begin
                rows_d  = grn_q[front_sel_q][col];
                colsg_d = 8'd1 << col;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BLANK;
            slot_q        <= 4'd0;
            cnt_q         <= '0;
            front_sel_q   <= 1'b0;
            swapped_q     <= 1'b0;
            red_q         <= '0;
            grn_q         <= '0;
            rows_q        <= 8'h00;
            colsr_q       <= 8'h00;
            colsg_q       <= 8'h00;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
            bright_q      <= 3'd7;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            cnt_q         <= cnt_d;
            front_sel_q   <= front_sel_d;
            swapped_q     <= swapped_d;
            red_q         <= red_d;
            grn_q         <= grn_d;
            rows_q        <= rows_d;
            colsr_q       <= colsr_d;
            colsg_q       <= colsg_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
`ifdef MATRIX_BRIGHTNESS_EN
            bright_q      <= bright_d;
`endif
        end
    end

    assign rows            = rows_q;
    assign colsr           = colsr_q;
    assign colsg           = colsg_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_matrix_frame_scanner.sv
// Directed bench for matrix_frame_scanner: 10-cycle slots, 2 blank cycles, 160-cycle frames.
module tb_matrix_frame_scanner;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rows, colsr, colsg;
`ifdef MATRIX_BRIGHTNESS_EN
    logic [2:0] brightness;
`endif

    matrix_frame_scanner_if bus ();

    matrix_frame_scanner #(
        .CLK_HZ       (1600),
        .FRAME_HZ     (10),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
`ifdef MATRIX_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .rows       (rows),
        .colsr      (colsr),
        .colsg      (colsg)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         p           = 0;
    int         m_bright    = 7;
    int         hit_cnt     = 0;
    int         ack_cnt     = 0;
    logic       m_front     = 1'b0;
    logic       ack_next    = 1'b0;
    logic [7:0] m_red [2][8];
    logic [7:0] m_grn [2][8];
    logic [7:0] hit_rows = 8'hFF, hit_r = 8'hFF, hit_g = 8'hFF;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, p, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 8; c++) begin
                m_red[b][c] = 8'h00;
                m_grn[b][c] = 8'h00;
            end
        m_front  = 1'b0;
        ack_next = 1'b0;
    endtask

    // Pins after the p-th edge since reset release show scan position p-1.
    task automatic run(input int n);
        int idx, slot, cnt, cl, d;
        logic [7:0] er, ecr, ecg;
        logic ea;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            p++;
            idx  = p - 1;
            slot = (idx / 10) % 16;
            cnt  = idx % 10;
            cl   = slot / 2;
`ifdef MATRIX_BRIGHTNESS_EN
            if (idx % 160 == 0) m_bright = int'(brightness);
`endif
            d = (8 * (m_bright + 1)) >> 3;
            if (d < 1) d = 1;
            er = 8'h00; ecr = 8'h00; ecg = 8'h00;
            if (cnt >= 2 && cnt < 2 + d) begin
                if (slot % 2 == 0) begin
                    er  = m_red[m_front][cl];
                    ecr = 8'd1 << cl;
                end else begin
                    er  = m_grn[m_front][cl];
                    ecg = 8'd1 << cl;
                end
            end
            ea = ack_next;
            ack_next = 1'b0;
            chk("rows", rows, er);
            chk("colsr", colsr, ecr);
            chk("colsg", colsg, ecg);
            chk("frame_start", 8'(bus.frame_start), 8'((idx % 160) == 0));
            chk("swap_ack", 8'(bus.swap_ack), 8'(ea));
            if (rows == hit_rows && colsr == hit_r && colsg == hit_g) hit_cnt++;
            if (bus.swap_ack) ack_cnt++;
            if (p % 160 == 0 && bus.swap_req) begin
                m_front  = ~m_front;
                ack_next = 1'b1;
            end
        end
    endtask

    task automatic wr(input logic [2:0] c, input logic [7:0] r, input logic [7:0] g);
        bus.wr_en  = 1'b1;
        bus.wr_col = c;
        bus.wr_red = r;
        bus.wr_grn = g;
        m_red[~m_front][c] = r;
        m_grn[~m_front][c] = g;
        run(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic set_hit(input logic [7:0] hr, input logic [7:0] hcr, input logic [7:0] hcg);
        hit_rows = hr; hit_r = hcr; hit_g = hcg;
        hit_cnt  = 0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_col   = 3'd0;
        bus.wr_red   = 8'h00;
        bus.wr_grn   = 8'h00;
        bus.swap_req = 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
        brightness   = 3'd7;
`endif
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rows", rows, 8'h00);
        chk("rst_colsr", colsr, 8'h00);
        chk("rst_colsg", colsg, 8'h00);
        chk("rst_swap_ack", 8'(bus.swap_ack), 8'h00);
        chk("rst_frame_start", 8'(bus.frame_start), 8'h00);
        reset = 1'b1;
        p = 0;
        #2;
        chk("rel_frame_start", 8'(bus.frame_start), 8'h00);

        // Blank frame, frame_start every 160 cycles
        run(161);

        // Col3 red in back buffer, swap, single c3R drive window
        wr(3'd3, 8'h1C, 8'h00);
        bus.swap_req = 1'b1;
        ack_cnt = 0;
        run(160 - (p % 160));
        bus.swap_req = 1'b0;
        set_hit(8'h1C, 8'h08, 8'h00);
        run(160);
        chk("s2_c3r_drive_cycles", 8'(hit_cnt), 8'd8);
        chk("s2_ack_count", 8'(ack_cnt), 8'd1);

        // Back-buffer write is invisible until swapped
        wr(3'd0, 8'hFF, 8'hFF);
        set_hit(8'hFF, 8'h01, 8'h00);
        run(159 - (p % 160) + 1);
        chk("s3_front_unchanged", 8'(hit_cnt), 8'd0);
        bus.swap_req = 1'b1;
        run(160);
        bus.swap_req = 1'b0;
        set_hit(8'hFF, 8'h01, 8'h00);
        run(160);
        chk("s3_c0r_drive_cycles", 8'(hit_cnt), 8'd8);
        set_hit(8'hFF, 8'h00, 8'h01);
        run(160);
        chk("s3_c0g_drive_cycles", 8'(hit_cnt), 8'd8);

        // Request mid-frame at slot 6, held across two boundaries
        run(62 - (p % 160));
        bus.swap_req = 1'b1;
        ack_cnt = 0;
        run(159 - (p % 160));
        chk("s4_no_early_swap", 8'(ack_cnt), 8'd0);
        run(1);
        set_hit(8'h1C, 8'h08, 8'h00);
        run(160);
        chk("s4_bank1_shown", 8'(hit_cnt), 8'd8);
        bus.swap_req = 1'b0;
        set_hit(8'hFF, 8'h01, 8'h00);
        run(161);
        chk("s4_bank0_shown", 8'(hit_cnt), 8'd8);
        chk("s4_ack_count", 8'(ack_cnt), 8'd2);

        // Reset during DRIVE of slot 9 (c4G)
        run(96 - (p % 160));
        chk("s5_pre_colsg", colsg, 8'h10);
        reset = 1'b0;
        #1;
        chk("s5_rst_rows", rows, 8'h00);
        chk("s5_rst_colsr", colsr, 8'h00);
        chk("s5_rst_colsg", colsg, 8'h00);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        p = 0;
        run(160);
        bus.swap_req = 1'b1;
        run(160);
        bus.swap_req = 1'b0;
        set_hit(8'h1C, 8'h08, 8'h00);
        run(160);
        chk("s5_bank1_cleared", 8'(hit_cnt), 8'd0);

`ifdef MATRIX_BRIGHTNESS_EN
        // Brightness-limited drive window in c5G
        wr(3'd5, 8'h00, 8'h81);
        brightness   = 3'd3;
        bus.swap_req = 1'b1;
        run(160 - (p % 160));
        bus.swap_req = 1'b0;
        set_hit(8'h81, 8'h00, 8'h20);
        run(160);
        chk("s6_bright3_cycles", 8'(hit_cnt), 8'd4);
        brightness = 3'd0;
        set_hit(8'h81, 8'h00, 8'h20);
        run(160);
        chk("s6_bright0_cycles", 8'(hit_cnt), 8'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
